branch_predictor: RTL and testbench
===================================

# branch_predictor

Parametrised dynamic branch predictor for the 5-stage pipeline. It is looked up in IF with the fetch PC and returns a predicted next PC. It is trained by branches and jumps resolved in EX. It raises a mispredict/redirect that replaces the fixed predict-not-taken flush. Storage is a direct-mapped BTB holding tag, target and a saturating direction counter per entry, plus saturating performance counters.

## Interface
Parameters:
- ENTRIES, 64, BTB entries; power of two, 4..1024; IDX_W = log2(ENTRIES)
- TAG_W, 8, stored tag bits; IDX_W+TAG_W+2 ≤ 32
- CTR_W, 2, direction counter width, 1..4
- PERF_W, 16, performance counter width

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all valid bits, counters and perf counters
- if_pc  in  32  fetch PC (word aligned)
- pred_hit  out  1  BTB tag match for if_pc
- pred_taken  out  1  predicted taken
- pred_target  out  32  predicted next PC
- upd_valid  in  1  a branch/jump resolved in EX this cycle
- upd_is_jump  in  1  resolved instruction is unconditional (j/jal/jr/jalr)
- upd_pc  in  32  PC of resolved instruction
- upd_taken  in  1  actual outcome
- upd_target  in  32  actual taken target
- upd_pred_taken  in  1  prediction carried down the pipeline with the instruction
- upd_pred_target  in  32  predicted target carried down
- clear  in  1  synchronous invalidate of all entries (perf counters kept)
- mispredict  out  1  redirect required
- redirect_pc  out  32  correct next PC
- perf_branches  out  PERF_W  resolved count, saturating
- perf_mispredicts  out  PERF_W  mispredict count, saturating

## Operation
- idx(pc) = pc[IDX_W+1:2]; tag(pc) = pc[IDX_W+TAG_W+1:IDX_W+2].
- Lookup (combinational): pred_hit = valid[idx] && tag[idx]==tag(if_pc); pred_taken = pred_hit && ctr[idx][CTR_W-1]; pred_target = pred_taken ? target[idx] : if_pc+4 (mod 2^32).
- Resolve (combinational, gated by upd_valid):
  - mispredict = upd_taken≠upd_pred_taken || (upd_taken && upd_target≠upd_pred_target).
  - redirect_pc = upd_taken ? upd_target : upd_pc+4.
  - Both are 0 when upd_valid=0.
- Training on a clock edge with upd_valid=1:
  - On a hit, the counter increments if taken and decrements if not, saturating at 0 and 2^CTR_W−1. target is overwritten with upd_target when taken.
  - On a miss with taken: allocate the entry (replacing any occupant), set valid, tag and target; ctr = 2^(CTR_W−1) (weakly taken).
  - On a miss with not taken: no change.
  - upd_is_jump forces ctr to 2^CTR_W−1 on both hit and allocate.
- Perf counters: perf_branches +1 per upd_valid; perf_mispredicts +1 per mispredict; both saturate at 2^PERF_W−1.
- clear=1: all valid←0 next edge. Any training in the same cycle is discarded. Perf counters still count.

## Timing
- Lookup and resolve outputs have zero latency (combinational from inputs and state). Training is visible to lookups from the cycle after the edge.
- A lookup and a training to the same index in the same cycle: the lookup sees the old state; there is no bypass.
- Reset (async assert, any time, including mid-training): all valid=0, ctr=0, perf=0 immediately. Outputs become pred_hit=0, pred_taken=0, pred_target=if_pc+4. Deassertion is sampled by clk; the first training can occur on the first edge with reset=1.
- The block has no stall input. The pipeline holds upd_valid low while EX is bubbled or flushed.

## Structure
- Package bp_pkg holds the clog2-based IDX_W function, idx/tag extract functions, and the weakly-taken/strong-taken constants derived from CTR_W.
- The sub-module sat_ctr (width parameter, inc/dec/load/clear, saturating) is instantiated for the two perf counters. The direction-counter update reuses its combinational next-value function from the package.
- The BTB uses flat reg arrays (valid, tag, target, ctr) indexed by idx.

## Test plan
(ENTRIES=64, TAG_W=8, CTR_W=2)
- Reset, then if_pc=0x00400010 -> pred_hit=0, pred_taken=0, pred_target=0x00400014; perf counters 0.
- Resolve upd_pc=0x00400010 taken to 0x00400100 with pred_taken=0 -> mispredict=1, redirect=0x00400100. Next cycle, lookup 0x00400010 -> hit, taken, target 0x00400100.
- Same branch resolved not-taken twice, correctly predicted taken then not -> ctr 2→1→0. Lookup gives pred_taken=0 and target pc+4. The second resolve has mispredict=0, redirect 0x00400014.
- Alias 0x00401010 (same idx, tag 0x10) resolved taken -> replaces the entry. Lookup 0x00400010 -> pred_hit=0.
- Jump at 0x00400020 with upd_is_jump: ctr=3. A later not-taken update gives ctr=2, still predicted taken. clear=1 -> pred_hit=0 next cycle.
- Drive 2^16+5 upd_valid mispredicts -> both perf counters hold 0xFFFF. Async reset mid-burst -> both 0 without a clock edge.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared helpers for the branch predictor.
//   bp_clog2       : ceil(log2(n)), used to size the BTB index
//   bp_idx/bp_tag  : BTB index and tag fields of a word-aligned PC
//   bp_ctr_weak    : weakly-taken counter value for a given counter width
//   bp_ctr_strong  : strongly-taken (all ones) value for a given width
//   bp_sat_next    : saturating inc/dec next-value, shared by the direction
//                    counters and the sat_ctr module
package bp_pkg;

    function automatic int bp_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic logic [31:0] bp_idx(input logic [31:0] pc, input int idx_w);
        return (pc >> 2) & ((32'h1 << idx_w) - 32'h1);
    endfunction

    function automatic logic [31:0] bp_tag(input logic [31:0] pc, input int idx_w,
                                           input int tag_w);
        return (pc >> (idx_w + 2)) & ((32'h1 << tag_w) - 32'h1);
    endfunction

    function automatic logic [31:0] bp_ctr_weak(input int ctr_w);
        return 32'h1 << (ctr_w - 1);
    endfunction

    // For ctr_w == 32 the shift wraps to 0 and the subtraction yields all ones.
    function automatic logic [31:0] bp_ctr_strong(input int ctr_w);
        return (32'h1 << ctr_w) - 32'h1;
    endfunction

    // Simultaneous inc and dec cancel; the value sticks at 0 and at max.
    function automatic logic [31:0] bp_sat_next(input logic [31:0] cur, input logic inc,
                                                input logic dec, input logic [31:0] max);
        logic [31:0] nxt;
        nxt = cur;
        if (inc && !dec && (cur != max)) begin
            nxt = cur + 32'd1;
        end else if (dec && !inc && (cur != 32'd0)) begin
            nxt = cur - 32'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sat_ctr.sv
// Saturating up/down counter with load and synchronous clear.
//   clk, reset (async, active-low)
//   inc, dec     : step up / down, saturating at 0 and 2^W-1
//   load/load_val: synchronous load (priority below clr)
//   clr          : synchronous clear to 0 (highest priority)
//   q            : counter value
module sat_ctr
    import bp_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         clr,
    output logic [W-1:0] q
);

    localparam logic [31:0] MAX = bp_ctr_strong(W);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else begin
            q <= W'(bp_sat_next(32'(q), inc, dec, MAX));
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB branch predictor with saturating direction counters.
//   clk, reset (async, active-low)
//   Lookup (IF)  : if_pc -> pred_hit, pred_taken, pred_target (combinational)
//   Resolve (EX) : upd_* -> mispredict, redirect_pc (combinational), and
//                  training of the BTB on the clock edge
//   clear        : invalidates every entry on the next edge
//   perf_*       : saturating resolved-branch / mispredict counts
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 8,
    parameter int CTR_W   = 2,
    parameter int PERF_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       if_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [31:0]       pred_target,
    input  logic              upd_valid,
    input  logic              upd_is_jump,
    input  logic [31:0]       upd_pc,
    input  logic              upd_taken,
    input  logic [31:0]       upd_target,
    input  logic              upd_pred_taken,
    input  logic [31:0]       upd_pred_target,
    input  logic              clear,
    output logic              mispredict,
    output logic [31:0]       redirect_pc,
    output logic [PERF_W-1:0] perf_branches,
    output logic [PERF_W-1:0] perf_mispredicts
);

    localparam int                IDX_W      = bp_clog2(ENTRIES);
    localparam logic [31:0]       CTR_MAX32  = bp_ctr_strong(CTR_W);
    localparam logic [CTR_W-1:0]  CTR_STRONG = CTR_W'(CTR_MAX32);
    localparam logic [CTR_W-1:0]  CTR_WEAK   = CTR_W'(bp_ctr_weak(CTR_W));

    // Valid bits and direction counters are control state (reset);
    // tags and targets are data, qualified by valid.
    logic [ENTRIES-1:0]            valid_q;
    logic [ENTRIES-1:0][CTR_W-1:0] ctr_q;
    logic [TAG_W-1:0]              tag_q    [ENTRIES];
    logic [31:0]                   target_q [ENTRIES];

    // ---- Lookup ----
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;

    assign lk_idx      = IDX_W'(bp_idx(if_pc, IDX_W));
    assign lk_tag      = TAG_W'(bp_tag(if_pc, IDX_W, TAG_W));
    assign pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign pred_taken  = pred_hit && ctr_q[lk_idx][CTR_W-1];
    assign pred_target = pred_taken ? target_q[lk_idx] : (if_pc + 32'd4);

    // ---- Resolve ----
    assign mispredict  = upd_valid &&
                         ((upd_taken != upd_pred_taken) ||
                          (upd_taken && (upd_target != upd_pred_target)));
    assign redirect_pc = !upd_valid ? 32'd0 :
                         (upd_taken ? upd_target : (upd_pc + 32'd4));

    // ---- Training ----
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;
    logic             do_hit;
    logic             do_alloc;
    logic [CTR_W-1:0] ctr_next;

    assign up_idx   = IDX_W'(bp_idx(upd_pc, IDX_W));
    assign up_tag   = TAG_W'(bp_tag(upd_pc, IDX_W, TAG_W));
    assign up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    // clear in the same cycle discards any training
    assign do_hit   = upd_valid && !clear && up_hit;
    assign do_alloc = upd_valid && !clear && !up_hit && upd_taken;

    always_comb begin
        ctr_next = ctr_q[up_idx];
        if (do_hit) begin
            ctr_next = upd_is_jump ? CTR_STRONG :
                       CTR_W'(bp_sat_next(32'(ctr_q[up_idx]), upd_taken, !upd_taken, CTR_MAX32));
        end else if (do_alloc) begin
            ctr_next = upd_is_jump ? CTR_STRONG : CTR_WEAK;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            ctr_q   <= '0;
        end else if (clear) begin
            valid_q <= '0;
        end else begin
            if (do_alloc) begin
                valid_q[up_idx] <= 1'b1;
            end
            if (do_hit || do_alloc) begin
                ctr_q[up_idx] <= ctr_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_alloc) begin
            tag_q[up_idx] <= up_tag;
        end
        if (do_alloc || (do_hit && upd_taken)) begin
            target_q[up_idx] <= upd_target;
        end
    end

    // ---- Performance counters (unaffected by clear) ----
    sat_ctr #(.W(PERF_W)) u_perf_branches (
        .clk      (clk),
        .reset    (reset),
        .inc      (upd_valid),
        .dec      (1'b0),
        .load     (1'b0),
        .load_val ('0),
        .clr      (1'b0),
        .q        (perf_branches)
    );

    sat_ctr #(.W(PERF_W)) u_perf_mispredicts (
        .clk      (clk),
        .reset    (reset),
        .inc      (mispredict),
        .dec      (1'b0),
        .load     (1'b0),
        .load_val ('0),
        .clr      (1'b0),
        .q        (perf_mispredicts)
    );

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (ENTRIES=64, TAG_W=8,
// CTR_W=2, PERF_W=16). Inputs change just after the falling edge; outputs
// are sampled 1 time unit later, well clear of the rising edge.
module tb_branch_predictor;

    logic        clk;
    logic        reset;
    logic [31:0] if_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic        upd_is_jump;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        clear;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [15:0] perf_branches;
    logic [15:0] perf_mispredicts;

    branch_predictor #(
        .ENTRIES (64),
        .TAG_W   (8),
        .CTR_W   (2),
        .PERF_W  (16)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .if_pc            (if_pc),
        .pred_hit         (pred_hit),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .upd_valid        (upd_valid),
        .upd_is_jump      (upd_is_jump),
        .upd_pc           (upd_pc),
        .upd_taken        (upd_taken),
        .upd_target       (upd_target),
        .upd_pred_taken   (upd_pred_taken),
        .upd_pred_target  (upd_pred_target),
        .clear            (clear),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .perf_branches    (perf_branches),
        .perf_mispredicts (perf_mispredicts)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_chk;
    int          n_fail;
    logic [31:0] exp_q [$];
    string       tag_q [$];
    logic [15:0] exp_br;
    logic [15:0] exp_mp;

    // Scoreboard: the expectation is queued, then popped against the DUT.
    task automatic push_exp(input string t, input logic [31:0] e);
        tag_q.push_back(t);
        exp_q.push_back(e);
    endtask

    task automatic pop_chk(input string t, input logic [31:0] obs);
        logic [31:0] e;
        string       et;
        n_chk++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: observed %h with no expectation queued", t, obs);
        end else begin
            e  = exp_q.pop_front();
            et = tag_q.pop_front();
            assert (obs === e && et == t) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", t, obs, e);
            end
        end
    endtask

    task automatic check(input string t, input logic [31:0] obs, input logic [31:0] e);
        push_exp(t, e);
        pop_chk(t, obs);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_idle();
        upd_valid       = 1'b0;
        upd_is_jump     = 1'b0;
        upd_pc          = 32'd0;
        upd_taken       = 1'b0;
        upd_target      = 32'd0;
        upd_pred_taken  = 1'b0;
        upd_pred_target = 32'd0;
        clear           = 1'b0;
    endtask

    task automatic set_upd(input logic jmp, input logic [31:0] pc, input logic tk,
                           input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
        upd_valid       = 1'b1;
        upd_is_jump     = jmp;
        upd_pc          = pc;
        upd_taken       = tk;
        upd_target      = tgt;
        upd_pred_taken  = ptk;
        upd_pred_target = ptgt;
        clear           = 1'b0;
    endtask

    // Checks resolve outputs and advances the perf-counter model, whose
    // effect becomes visible after the next rising edge.
    task automatic chk_res(input logic mp, input logic [31:0] rpc);
        #1;
        check("mispredict", {31'd0, mispredict}, {31'd0, mp});
        check("redirect_pc", redirect_pc, rpc);
        if (upd_valid && exp_br != 16'hFFFF) exp_br = exp_br + 16'd1;
        if (mp && exp_mp != 16'hFFFF) exp_mp = exp_mp + 16'd1;
    endtask

    task automatic look(input logic [31:0] pc, input logic hit, input logic tk,
                        input logic [31:0] tgt);
        if_pc = pc;
        #1;
        check("pred_hit", {31'd0, pred_hit}, {31'd0, hit});
        check("pred_taken", {31'd0, pred_taken}, {31'd0, tk});
        check("pred_target", pred_target, tgt);
    endtask

    task automatic chk_perf(input logic [15:0] br, input logic [15:0] mp);
        check("perf_branches", {16'd0, perf_branches}, {16'd0, br});
        check("perf_mispredicts", {16'd0, perf_mispredicts}, {16'd0, mp});
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        exp_br = 16'd0;
        exp_mp = 16'd0;
        reset  = 1'b0;
        if_pc  = 32'h0040_0010;
        set_idle();

        // Reset state
        look(32'h0040_0010, 1'b0, 1'b0, 32'h0040_0014);
        chk_perf(16'd0, 16'd0);
        chk_res(1'b0, 32'd0);

        // First training on the first edge after reset release: allocate
        step();
        reset = 1'b1;
        set_upd(1'b0, 32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0, 32'd0);
        chk_res(1'b1, 32'h0040_0100);
        step();
        set_idle();
        look(32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100);
        chk_perf(exp_br, exp_mp);

        // Not-taken while predicted taken: ctr 2 -> 1
        step();
        set_upd(1'b0, 32'h0040_0010, 1'b0, 32'd0, 1'b1, 32'h0040_0100);
        chk_res(1'b1, 32'h0040_0014);
        step();
        set_idle();
        look(32'h0040_0010, 1'b1, 1'b0, 32'h0040_0014);

        // Correctly predicted not-taken: ctr 1 -> 0, then stays at 0
        step();
        set_upd(1'b0, 32'h0040_0010, 1'b0, 32'd0, 1'b0, 32'd0);
        chk_res(1'b0, 32'h0040_0014);
        step();
        set_upd(1'b0, 32'h0040_0010, 1'b0, 32'd0, 1'b0, 32'd0);
        chk_res(1'b0, 32'h0040_0014);
        // One taken from 0 gives 1: still predicted not-taken
        step();
        set_upd(1'b0, 32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0, 32'd0);
        chk_res(1'b1, 32'h0040_0100);
        step();
        set_idle();
        look(32'h0040_0010, 1'b1, 1'b0, 32'h0040_0014);

        // Taken with a wrong predicted target: retarget, ctr 1 -> 2
        step();
        set_upd(1'b0, 32'h0040_0010, 1'b1, 32'h0040_0200, 1'b1, 32'h0040_0100);
        chk_res(1'b1, 32'h0040_0200);
        step();
        set_idle();
        look(32'h0040_0010, 1'b1, 1'b1, 32'h0040_0200);
        chk_perf(exp_br, exp_mp);

        // Correct taken prediction
        step();
        set_upd(1'b0, 32'h0040_0010, 1'b1, 32'h0040_0200, 1'b1, 32'h0040_0200);
        chk_res(1'b0, 32'h0040_0200);

        // Alias with same index, different tag replaces the entry
        step();
        set_upd(1'b0, 32'h0040_1010, 1'b1, 32'h0040_2000, 1'b0, 32'd0);
        chk_res(1'b1, 32'h0040_2000);
        step();
        set_idle();
        look(32'h0040_0010, 1'b0, 1'b0, 32'h0040_0014);
        look(32'h0040_1010, 1'b1, 1'b1, 32'h0040_2000);

        // Jump allocates strongly taken; lookup in the same cycle sees old state
        step();
        set_upd(1'b1, 32'h0040_0020, 1'b1, 32'h0040_0800, 1'b0, 32'd0);
        chk_res(1'b1, 32'h0040_0800);
        look(32'h0040_0020, 1'b0, 1'b0, 32'h0040_0024);
        step();
        set_idle();
        look(32'h0040_0020, 1'b1, 1'b1, 32'h0040_0800);
        // 3 -> 2: still taken
        step();
        set_upd(1'b0, 32'h0040_0020, 1'b0, 32'd0, 1'b1, 32'h0040_0800);
        chk_res(1'b1, 32'h0040_0024);
        step();
        set_idle();
        look(32'h0040_0020, 1'b1, 1'b1, 32'h0040_0800);
        // 2 -> 1: not taken
        step();
        set_upd(1'b0, 32'h0040_0020, 1'b0, 32'd0, 1'b1, 32'h0040_0800);
        chk_res(1'b1, 32'h0040_0024);
        step();
        set_idle();
        look(32'h0040_0020, 1'b1, 1'b0, 32'h0040_0024);
        // Jump on a hit forces 3 and retargets; one not-taken leaves it taken
        step();
        set_upd(1'b1, 32'h0040_0020, 1'b1, 32'h0040_0900, 1'b0, 32'd0);
        chk_res(1'b1, 32'h0040_0900);
        step();
        set_upd(1'b0, 32'h0040_0020, 1'b0, 32'd0, 1'b1, 32'h0040_0900);
        chk_res(1'b1, 32'h0040_0024);
        step();
        set_idle();
        look(32'h0040_0020, 1'b1, 1'b1, 32'h0040_0900);

        // Clear with a same-cycle allocation: everything invalid, perf still counts
        step();
        set_upd(1'b0, 32'h0040_0040, 1'b1, 32'h0040_0444, 1'b0, 32'd0);
        clear = 1'b1;
        chk_res(1'b1, 32'h0040_0444);
        step();
        set_idle();
        look(32'h0040_0020, 1'b0, 1'b0, 32'h0040_0024);
        look(32'h0040_0040, 1'b0, 1'b0, 32'h0040_0044);
        look(32'h0040_1010, 1'b0, 1'b0, 32'h0040_1014);
        chk_perf(exp_br, exp_mp);
        chk_res(1'b0, 32'd0);

        // Saturation burst: 2^16+5 mispredicted resolves
        for (int i = 0; i < 65541; i++) begin
            step();
            set_upd(1'b0, 32'h0040_0080, 1'b1, 32'h0040_0888, 1'b0, 32'd0);
        end
        step();
        set_idle();
        chk_perf(16'hFFFF, 16'hFFFF);
        look(32'h0040_0080, 1'b1, 1'b1, 32'h0040_0888);

        // Async reset in the middle of a burst, between clock edges
        for (int i = 0; i < 3; i++) begin
            step();
            set_upd(1'b0, 32'h0040_0080, 1'b1, 32'h0040_0888, 1'b0, 32'd0);
        end
        #2;
        reset = 1'b0;
        #1;
        chk_perf(16'd0, 16'd0);
        look(32'h0040_0080, 1'b0, 1'b0, 32'h0040_0084);
        step();
        set_idle();
        reset = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
